// File: rtl/ddr5_cmd_responder_if.sv
// ddr5_cmd_responder_if: scheduler command bus plus read/write/error returns; DDR5_RESP_STATS_EN adds counters.
interface ddr5_cmd_responder_if;
  logic [3:0] cmd;
  logic [2:0] cmd_bg;
  logic [1:0] cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0] cmd_col;
  logic rd_valid;
  logic [2:0] rd_bg;
  logic [1:0] rd_ba;
  logic [9:0] rd_col;
  logic wr_done;
  logic [2:0] wr_bg;
  logic [1:0] wr_ba;
  logic [9:0] wr_col;
  logic err_valid;
  logic [2:0] err_code;
  logic busy;
`ifdef DDR5_RESP_STATS_EN
  logic [31:0] rd_count, wr_count, err_count;
  modport master (
    output cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input rd_valid, rd_bg, rd_ba, rd_col, wr_done, wr_bg, wr_ba, wr_col, err_valid, err_code, busy,
    input rd_count, wr_count, err_count
  );
  modport slave (
    input cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output rd_valid, rd_bg, rd_ba, rd_col, wr_done, wr_bg, wr_ba, wr_col, err_valid, err_code, busy,
    output rd_count, wr_count, err_count
  );
`else
  modport master (
    output cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input rd_valid, rd_bg, rd_ba, rd_col, wr_done, wr_bg, wr_ba, wr_col, err_valid, err_code, busy
  );
  modport slave (
    input cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output rd_valid, rd_bg, rd_ba, rd_col, wr_done, wr_bg, wr_ba, wr_col, err_valid, err_code, busy
  );
`endif
endinterface

// File: rtl/ddr5_cmd_responder.sv
// ddr5_cmd_responder: DDR5 bank-state responder with timing checks and read/write returns.
// Define DDR5_RESP_STATS_EN to add rd_count/wr_count/err_count.
module ddr5_cmd_responder #(
  parameter int TRCD = 39,
  parameter int TRP = 39,
  parameter int TRAS = 76,
  parameter int TRC = 115,
  parameter int TRFC = 295,
  parameter int TCL = 40,
  parameter int TCWD = 38,
  parameter int TBURST = 8
) (
  input logic clock,
  input logic reset,
  ddr5_cmd_responder_if.slave bus
);
  localparam int TWR = TCWD + TBURST;
  localparam logic [8:0] TRCD9 = 9'(TRCD);
  localparam logic [8:0] TRP9 = 9'(TRP);
  localparam logic [8:0] TRAS9 = 9'(TRAS);
  localparam logic [8:0] TRC9 = 9'(TRC);
  localparam logic [8:0] TRFC9 = 9'(TRFC);
  localparam logic [3:0] C_NULL = 4'd0, C_ACT0 = 4'd1, C_ACT1 = 4'd2, C_RD0 = 4'd3, C_RD1 = 4'd4;
  localparam logic [3:0] C_WR0 = 4'd5, C_WR1 = 4'd6, C_PRE = 4'd7, C_REF = 4'd8;
  typedef enum logic [1:0] {IDLE, WAIT_ACT1, WAIT_RD1, WAIT_WR1} state_t;
  state_t state, state_nx;
  logic [31:0] bank_open, open_nx;
  logic [31:0][8:0] act_age, pre_age, act_nx, pre_nx;
  logic [15:0] open_row_unused [32];
  logic [8:0] busy_cnt;
  logic [2:0] l_bg;
  logic [1:0] l_ba;
  logic [15:0] l_row;
  logic [4:0] bank;
  logic [8:0] aa, pa;
  logic is_open, match, rdwr0;
  logic do_act1, do_rd, do_wr, do_pre, do_ref;
  logic [7:1] f;
  logic [2:0] code;
  logic [TCL-1:0][15:0] rd_line;
  logic [TWR-1:0][15:0] wr_line;
  assign bank = {bus.cmd_bg, bus.cmd_ba};
  assign aa = act_age[bank];
  assign pa = pre_age[bank];
  assign is_open = bank_open[bank];
  assign match = bus.cmd_bg == l_bg && bus.cmd_ba == l_ba;
  assign rdwr0 = bus.cmd == C_RD0 || bus.cmd == C_WR0;
  assign bus.busy = busy_cnt != '0;
  assign {bus.rd_valid, bus.rd_bg, bus.rd_ba, bus.rd_col} = rd_line[TCL-1];
  assign {bus.wr_done, bus.wr_bg, bus.wr_ba, bus.wr_col} = wr_line[TWR-1];
  always_comb begin
    state_nx = IDLE;
    f = '0;
    do_act1 = 1'b0;
    do_rd = 1'b0;
    do_wr = 1'b0;
    do_pre = 1'b0;
    do_ref = 1'b0;
    if (state != IDLE) begin
      do_act1 = state == WAIT_ACT1 && bus.cmd == C_ACT1 && match && bus.cmd_row == l_row;
      do_rd = state == WAIT_RD1 && bus.cmd == C_RD1 && match;
      do_wr = state == WAIT_WR1 && bus.cmd == C_WR1 && match;
      f[1] = !(do_act1 || do_rd || do_wr);
    end else begin
      f[1] = bus.cmd > C_REF || bus.cmd == C_ACT1 || bus.cmd == C_RD1 || bus.cmd == C_WR1;
      f[2] = bus.cmd == C_ACT0 && is_open;
      f[3] = rdwr0 && !is_open;
      f[4] = rdwr0 && aa < TRCD9;
      f[5] = bus.cmd == C_ACT0 && (pa < TRP9 || aa < TRC9);
      f[6] = bus.cmd == C_PRE && is_open && aa < TRAS9;
      f[7] = (bus.busy && bus.cmd != C_NULL) || (bus.cmd == C_REF && |bank_open);
      if (f == '0) begin
        state_nx = bus.cmd == C_ACT0 ? WAIT_ACT1 : bus.cmd == C_RD0 ? WAIT_RD1 : bus.cmd == C_WR0 ? WAIT_WR1 : IDLE;
        do_pre = bus.cmd == C_PRE && is_open;
        do_ref = bus.cmd == C_REF;
      end
    end
    code = f[1] ? 3'd1 : f[2] ? 3'd2 : f[3] ? 3'd3 : f[4] ? 3'd4 : f[5] ? 3'd5 : f[6] ? 3'd6 : f[7] ? 3'd7 : 3'd0;
  end
  // ages restart at 1 so that in cycle c the stored value equals c minus the command cycle
  for (genvar g = 0; g < 32; g++) begin : g_bank
    assign act_nx[g] = do_act1 && bank == 5'(g) ? 9'd1 : act_age[g] + 9'(act_age[g] != '1);
    assign pre_nx[g] = do_pre && bank == 5'(g) ? 9'd1 : pre_age[g] + 9'(pre_age[g] != '1);
    assign open_nx[g] = bank == 5'(g) ? (bank_open[g] | do_act1) & ~do_pre : bank_open[g];
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      bank_open <= '0;
      act_age <= '1;
      pre_age <= '1;
      busy_cnt <= '0;
      rd_line <= '0;
      wr_line <= '0;
      bus.err_valid <= 1'b0;
      bus.err_code <= '0;
    end else begin
      state <= state_nx;
      bank_open <= open_nx;
      act_age <= act_nx;
      pre_age <= pre_nx;
      busy_cnt <= do_ref ? TRFC9 : busy_cnt - 9'(bus.busy);
      rd_line <= {rd_line[TCL-2:0], do_rd, do_rd ? {bus.cmd_bg, bus.cmd_ba, bus.cmd_col} : 15'd0};
      wr_line <= {wr_line[TWR-2:0], do_wr, do_wr ? {bus.cmd_bg, bus.cmd_ba, bus.cmd_col} : 15'd0};
      bus.err_valid <= code != '0;
      bus.err_code <= code;
    end
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      l_bg <= bus.cmd_bg;
      l_ba <= bus.cmd_ba;
      l_row <= bus.cmd_row;
    end
    if (do_act1) open_row_unused[bank] <= l_row;
  end
`ifdef DDR5_RESP_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      bus.rd_count <= '0;
      bus.wr_count <= '0;
      bus.err_count <= '0;
    end else begin
      bus.rd_count <= bus.rd_count + 32'(do_rd);
      bus.wr_count <= bus.wr_count + 32'(do_wr);
      bus.err_count <= bus.err_count + 32'(bus.err_valid);
    end
`endif
endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// tb_ddr5_cmd_responder: directed and random command streams scored against a cycle-stamped reference model.
module tb_ddr5_cmd_responder;
  localparam int TRCD = 39, TRP = 39, TRAS = 76, TRC = 115, TRFC = 295, TCL = 40, TCWD = 38, TBURST = 8;
  localparam logic [3:0] C_NULL = 4'd0, C_ACT0 = 4'd1, C_ACT1 = 4'd2, C_RD0 = 4'd3, C_RD1 = 4'd4;
  localparam logic [3:0] C_WR0 = 4'd5, C_WR1 = 4'd6, C_PRE = 4'd7, C_REF = 4'd8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  ddr5_cmd_responder_if bus();
  ddr5_cmd_responder dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {int k; int cyc; logic [14:0] tag;} ev_t;
  ev_t exq[$];
  int checks = 0, errors = 0, cyc = 0, base = 0;
  bit mon_en = 0;
  bit open_b[32];
  int t_act[32], t_pre[32];
  int busy_lo = 1, busy_hi = 0;
  int pend = 0, pbank = 0;
  logic [15:0] prow;
  function automatic void expect_ev(int k, int at, logic [14:0] tag);
    ev_t e;
    e.k = k;
    e.cyc = at;
    e.tag = tag;
    exq.push_back(e);
  endfunction
  function automatic void model_reset(int t);
    foreach (open_b[i]) begin
      open_b[i] = 0;
      t_act[i] = t - 1000;
      t_pre[i] = t - 1000;
    end
    pend = 0;
    if (busy_hi > t) busy_hi = t;
    for (int i = exq.size() - 1; i >= 0; i--) if (exq[i].cyc > t) exq.delete(i);
  endfunction
  // lowest error class wins, so rules are applied from 7 down to 1
  function automatic void model(int t, logic [3:0] c, logic [2:0] bg, logic [1:0] ba, logic [15:0] row, logic [9:0] col);
    int b, ci, code;
    bit any_open;
    b = int'({bg, ba});
    ci = int'(c);
    code = 0;
    any_open = 0;
    foreach (open_b[i]) any_open |= open_b[i];
    if (pend != 0) begin
      if (ci == pend && b == pbank && (pend != 2 || row == prow)) begin
        if (pend == 2) begin
          open_b[b] = 1;
          t_act[b] = t;
        end else if (pend == 4) expect_ev(0, t + TCL, {bg, ba, col});
        else expect_ev(1, t + TCWD + TBURST, {bg, ba, col});
      end else code = 1;
      pend = 0;
    end else begin
      if ((t >= busy_lo && t <= busy_hi && ci != 0) || (ci == 8 && any_open)) code = 7;
      if (ci == 7 && open_b[b] && t - t_act[b] < TRAS) code = 6;
      if (ci == 1 && (t - t_pre[b] < TRP || t - t_act[b] < TRC)) code = 5;
      if ((ci == 3 || ci == 5) && t - t_act[b] < TRCD) code = 4;
      if ((ci == 3 || ci == 5) && !open_b[b]) code = 3;
      if (ci == 1 && open_b[b]) code = 2;
      if (ci > 8 || ci == 2 || ci == 4 || ci == 6) code = 1;
      if (code == 0) begin
        if (ci == 1 || ci == 3 || ci == 5) begin
          pend = ci + 1;
          pbank = b;
          prow = row;
        end else if (ci == 7 && open_b[b]) begin
          open_b[b] = 0;
          t_pre[b] = t;
        end else if (ci == 8) begin
          busy_lo = t + 1;
          busy_hi = t + TRFC;
        end
      end
    end
    if (code != 0) expect_ev(2, t + 1, 15'(code));
  endfunction
  task automatic step(logic [3:0] c, logic [2:0] bg = 3'd0, logic [1:0] ba = 2'd0, logic [15:0] row = 16'd0, logic [9:0] col = 10'd0);
    bus.cmd = c;
    bus.cmd_bg = bg;
    bus.cmd_ba = ba;
    bus.cmd_row = row;
    bus.cmd_col = col;
    if (reset) model_reset(cyc);
    else model(cyc, c, bg, ba, row, col);
    @(posedge clock);
    #1 cyc++;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(C_NULL);
    reset = 1'b0;
  endtask
  task automatic run_to(int n);
    while (cyc < base + n) step(C_NULL);
  endtask
  task automatic watch(int k, logic v, logic [14:0] got, string nm);
    int idx;
    idx = -1;
    for (int i = exq.size() - 1; i >= 0; i--)
      if (exq[i].k == k && exq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed: no pulse at cycle %0d, required tag %h", nm, exq[i].cyc, exq[i].tag);
        exq.delete(i);
      end
    foreach (exq[i]) if (exq[i].k == k && exq[i].cyc == cyc) idx = i;
    if (v === 1'b1) begin
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL %s unexpected at cycle %0d: got tag %h, required no pulse", nm, cyc, got);
      end else begin
        if (exq[idx].tag !== got) begin
          errors++;
          $display("FAIL %s tag at cycle %0d: got %h, required %h", nm, cyc, got, exq[idx].tag);
        end
        exq.delete(idx);
      end
    end
  endtask
  always @(negedge clock)
    if (mon_en) begin
      checks++;
      if (bus.busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
        errors++;
        $display("FAIL busy at cycle %0d: got %b, required %b", cyc, bus.busy, cyc >= busy_lo && cyc <= busy_hi);
      end
      watch(0, bus.rd_valid, {bus.rd_bg, bus.rd_ba, bus.rd_col}, "rd_valid");
      watch(1, bus.wr_done, {bus.wr_bg, bus.wr_ba, bus.wr_col}, "wr_done");
      watch(2, bus.err_valid, {12'd0, bus.err_code}, "err");
    end
  initial begin
    int op, m;
    logic [2:0] bg;
    logic [1:0] ba;
    logic [15:0] row;
    logic [3:0] c1;
    repeat (3) step(C_NULL);
    reset = 1'b0;
    mon_en = 1;
    // read after tRCD returns at RD1 + TCL
    do_reset();
    base = cyc;
    run_to(10);
    step(C_ACT0, 3'd2, 2'd1, 16'h1234);
    step(C_ACT1, 3'd2, 2'd1, 16'h1234);
    run_to(50);
    step(C_RD0, 3'd2, 2'd1);
    step(C_RD1, 3'd2, 2'd1, 16'd0, 10'h03F);
    run_to(100);
    // tRCD one short
    do_reset();
    base = cyc;
    run_to(10);
    step(C_ACT0, 3'd2, 2'd1, 16'h1234);
    step(C_ACT1, 3'd2, 2'd1, 16'h1234);
    run_to(49);
    step(C_RD0, 3'd2, 2'd1);
    run_to(100);
    // tRAS, tRP and tRC edges
    do_reset();
    base = cyc;
    run_to(10);
    step(C_ACT0, 3'd0, 2'd0, 16'h0042);
    step(C_ACT1, 3'd0, 2'd0, 16'h0042);
    run_to(86);
    step(C_PRE);
    step(C_PRE);
    run_to(125);
    step(C_ACT0, 3'd0, 2'd0, 16'h0007);
    step(C_ACT0, 3'd0, 2'd0, 16'h0007);
    step(C_ACT1, 3'd0, 2'd0, 16'h0007);
    run_to(135);
    // broken pair leaves the bank closed
    do_reset();
    base = cyc;
    run_to(5);
    step(C_ACT0, 3'd3, 2'd2, 16'h0100);
    step(C_NULL);
    run_to(20);
    step(C_RD0, 3'd3, 2'd2);
    run_to(25);
    // refresh window
    do_reset();
    base = cyc;
    step(C_REF);
    run_to(200);
    step(C_ACT0, 3'd1, 2'd3, 16'h0009);
    run_to(296);
    step(C_ACT0, 3'd1, 2'd3, 16'h0009);
    step(C_ACT1, 3'd1, 2'd3, 16'h0009);
    run_to(300);
    // reset discards an in-flight write
    do_reset();
    base = cyc + 40;
    step(C_ACT0, 3'd5, 2'd2, 16'hBEEF);
    step(C_ACT1, 3'd5, 2'd2, 16'hBEEF);
    run_to(19);
    step(C_WR0, 3'd5, 2'd2);
    step(C_WR1, 3'd5, 2'd2, 16'd0, 10'h155);
    run_to(30);
    reset = 1'b1;
    step(C_NULL);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.rd_valid, bus.rd_bg, bus.rd_ba, bus.rd_col, bus.wr_done, bus.wr_bg, bus.wr_ba, bus.wr_col,
         bus.err_valid, bus.err_code, bus.busy} !== 37'd0) begin
      errors++;
      $display("FAIL outputs after reset: got nonzero, required all 0");
    end
    run_to(70);
    // random traffic on four banks
    repeat (400) begin
      op = int'($urandom_range(0, 99));
      bg = 3'($urandom_range(0, 1));
      ba = 2'($urandom_range(0, 1));
      row = 16'($urandom_range(0, 3) * 32'h1111);
      c1 = op < 25 ? C_ACT0 : op < 50 ? C_RD0 : op < 65 ? C_WR0 : op < 82 ? C_PRE : op < 85 ? C_REF :
           op < 89 ? 4'($urandom_range(9, 15)) : C_NULL;
      if (op >= 97) do_reset();
      else begin
        step(c1, bg, ba, row, 10'($urandom));
        if (c1 == C_ACT0 || c1 == C_RD0 || c1 == C_WR0) begin
          m = int'($urandom_range(0, 11));
          step(m == 0 ? C_NULL : c1 + 4'd1, m == 1 ? bg ^ 3'd1 : bg, ba, m == 2 ? row + 16'd1 : row, 10'($urandom));
        end
      end
      repeat ($urandom_range(0, 45)) step(C_NULL);
    end
    repeat (TCWD + TBURST + 10) step(C_NULL);
    foreach (exq[i]) begin
      checks++;
      errors++;
      $display("FAIL pending event kind %0d never seen: required at cycle %0d tag %h", exq[i].k, exq[i].cyc, exq[i].tag);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
